// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues sequential fetches, buffers in-order responses, flushes on redirect.
// Optional misaligned-redirect trap entry enabled by defining IF_PREFETCH_MISALIGN_TRAP_EN.
module if_prefetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus_4
`ifdef IF_PREFETCH_MISALIGN_TRAP_EN
  ,
  output logic        inst_fault
`endif
);

  localparam int          PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W  = $clog2(DEPTH + 1);
  localparam int          OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] DEPTH_U = DEPTH;
  localparam logic [31:0] MAXO_U  = MAX_OUTSTANDING;

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_resp_pc;
  logic [CNT_W-1:0] r_count;
  logic [OUT_W-1:0] r_outstanding;
  logic [OUT_W-1:0] r_drop_cnt;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [31:0]      r_pc_mem   [DEPTH];
  logic [31:0]      r_data_mem [DEPTH];

  logic [31:0]      w_target;
  logic [31:0]      w_inflight;
  logic             w_halt;
  logic             w_accept;
  logic             w_resp;
  logic             w_drop;
  logic             w_push_resp;
  logic             w_push_trap;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_push_pc;
  logic [31:0]      w_push_data;
  logic [31:0]      w_trap_pc;
  logic [CNT_W-1:0] w_count_next;
  logic [OUT_W-1:0] w_outstanding_next;

  // Low address bits are always discarded for the fetch target; a misaligned
  // target is reported separately by the trap logic when that is enabled.
  assign w_target   = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};
  assign w_inflight = 32'(r_count) + 32'(r_outstanding);

  assign imem_req  = !rst && !redirect && !w_halt &&
                     (w_inflight < DEPTH_U) && (32'(r_outstanding) < MAXO_U);
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;

  // A response with nothing outstanding is a leftover from before reset.
  assign w_resp      = imem_rvalid && (r_outstanding != '0);
  assign w_drop      = w_resp && (r_drop_cnt != '0);
  assign w_push_resp = w_resp && !rst && !redirect && (r_drop_cnt == '0);
  assign w_push      = w_push_resp || w_push_trap;
  assign w_push_pc   = w_push_trap ? w_trap_pc : r_resp_pc;
  assign w_push_data = w_push_trap ? NOP : imem_rdata;

  assign inst_valid     = (r_count != '0) && !redirect;
  assign w_pop          = inst_valid && inst_ready;
  assign inst_data      = (r_count != '0) ? r_data_mem[r_rd_ptr] : NOP;
  assign inst_pc        = (r_count != '0) ? r_pc_mem[r_rd_ptr] : 32'h0000_0000;
  assign inst_pc_plus_4 = inst_pc + 32'd4;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CNT_W'(1);
    else if (!w_push && w_pop)
      w_count_next = r_count - CNT_W'(1);
  end

  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_accept && !w_resp)
      w_outstanding_next = r_outstanding + OUT_W'(1);
    else if (!w_accept && w_resp)
      w_outstanding_next = r_outstanding - OUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_drop_cnt <= w_outstanding_next;
      end else begin
        if (w_accept)
          r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push_resp)
          r_resp_pc <= r_resp_pc + 32'd4;
        if (w_drop)
          r_drop_cnt <= r_drop_cnt - OUT_W'(1);
        r_count <= w_count_next;
        if (w_push)
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= w_push_pc;
      r_data_mem[r_wr_ptr] <= w_push_data;
    end
  end

`ifdef IF_PREFETCH_MISALIGN_TRAP_EN
  logic        r_halt;
  logic        r_trap_pending;
  logic [31:0] r_trap_pc;
  logic        r_fault_mem [DEPTH];

  assign w_halt      = r_halt;
  assign w_push_trap = r_trap_pending && !rst && !redirect;
  assign w_trap_pc   = r_trap_pc;
  assign inst_fault  = (r_count != '0) && r_fault_mem[r_rd_ptr];

  // A misaligned target parks the fetcher until the next redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt         <= 1'b0;
      r_trap_pending <= 1'b0;
      r_trap_pc      <= '0;
    end else if (redirect) begin
      r_halt         <= (redirect_pc[1:0] != 2'b00);
      r_trap_pending <= (redirect_pc[1:0] != 2'b00);
      r_trap_pc      <= redirect_pc;
    end else if (w_push_trap) begin
      r_trap_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_fault_mem[r_wr_ptr] <= w_push_trap;
  end
`else
  assign w_halt      = 1'b0;
  assign w_push_trap = 1'b0;
  assign w_trap_pc   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue against an epoch-tagged transaction model.
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, redirect, imem_req, imem_ready, imem_rvalid;
  logic        inst_valid, inst_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst_data, inst_pc, inst_pc_plus_4;
`ifdef IF_PREFETCH_MISALIGN_TRAP_EN
  logic        inst_fault;
`endif

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pc_plus_4(inst_pc_plus_4)
`ifdef IF_PREFETCH_MISALIGN_TRAP_EN
    , .inst_fault(inst_fault)
`endif
  );

  typedef struct { logic [31:0] addr; int epoch; int cyc; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; logic fault; } ent_t;

  req_t        pend[$];
  ent_t        q[$];
  int          epoch = 0;
  int          cyc = 0;
  logic [31:0] m_fetch = RESET_PC;
  logic        m_halt = 1'b0;
  logic        m_trap_pend = 1'b0;
  logic [31:0] m_trap_pc = '0;
  int          tests_run = 0;
  int          tests_failed = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit mrdy,
                      input bit irdy, input int resp_pct, input bit stale);
    bit   resp, exp_req, exp_valid, pop;
    req_t h;
    @(negedge clk);
    rst = r; redirect = rd; redirect_pc = rpc; imem_ready = mrdy; inst_ready = irdy;
    resp = 1'b0;
    if (stale) begin
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    end else if (!r && pend.size() != 0 && pend[0].cyc < cyc &&
                 int'($urandom_range(99)) < resp_pct) begin
      resp = 1'b1; imem_rvalid = 1'b1; imem_rdata = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    exp_req   = !r && !rd && !m_halt && (q.size() + pend.size() < DEPTH) && (pend.size() < MAXO);
    exp_valid = (q.size() != 0) && !rd;
    check_eq("imem_req", 32'(imem_req), 32'(exp_req));
    if (!r) begin
      if (exp_req) check_eq("imem_addr", imem_addr, m_fetch);
      check_eq("inst_valid", 32'(inst_valid), 32'(exp_valid));
      if (q.size() != 0) begin
        check_eq("inst_pc", inst_pc, q[0].pc);
        check_eq("inst_data", inst_data, q[0].data);
        check_eq("inst_pc_plus_4", inst_pc_plus_4, q[0].pc + 32'd4);
`ifdef IF_PREFETCH_MISALIGN_TRAP_EN
        check_eq("inst_fault", 32'(inst_fault), 32'(q[0].fault));
`endif
      end
      if (stale) begin
        check_eq("reset_inst_pc", inst_pc, 32'h0);
        check_eq("reset_inst_data", inst_data, NOP);
      end
    end
    pop = exp_valid && irdy;
    if (r) begin
      pend.delete(); q.delete(); epoch++;
      m_fetch = RESET_PC; m_halt = 1'b0; m_trap_pend = 1'b0;
    end else if (rd) begin
      if (resp) void'(pend.pop_front());
      q.delete(); epoch++;
      m_fetch = {rpc[31:2], 2'b00};
`ifdef IF_PREFETCH_MISALIGN_TRAP_EN
      m_halt = (rpc[1:0] != 2'b00);
      m_trap_pend = m_halt;
      m_trap_pc = rpc;
`endif
    end else begin
      if (pop) void'(q.pop_front());
      if (m_trap_pend) begin
        q.push_back('{m_trap_pc, NOP, 1'b1});
        m_trap_pend = 1'b0;
      end
      if (resp) begin
        h = pend.pop_front();
        if (h.epoch == epoch) q.push_back('{h.addr, mem_word(h.addr), 1'b0});
      end
      if (exp_req && mrdy) begin
        pend.push_back('{m_fetch, epoch, cyc});
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    bit          r, prev_r, rd;
    logic [31:0] rpc;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0; inst_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    // Streaming: 1-cycle memory, consumer always ready; first cycle carries a stale response.
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 1, 100, i == 0);
    // Back-pressure fills the queue, then drains.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 100, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 100, 0);
    // Redirect with slow responses so requests are still in flight.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 32'h0000_0100, 1, 1, 100, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 70, 0);
    prev_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(199) == 0);
      rd  = !r && ($urandom_range(99) < 6);
      rpc = $urandom_range(3) == 0 ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                   : ($urandom & 32'h0000_0FFF);
`ifdef IF_PREFETCH_MISALIGN_TRAP_EN
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
`endif
      step(r, rd, rpc, $urandom_range(3) != 0, $urandom_range(2) != 0, 55, prev_r && !r);
      prev_r = r;
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
